// File: rtl/rs232_rx_drain_if.sv
// rs232_rx_drain_if: receive-buffer read port plus the outgoing valid/ready byte stream
interface rs232_rx_drain_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] iRx_addr;
    logic [ADDR_W-1:0] oRead_addr;
    logic [7:0]        iRx_data;
    logic [7:0]        oData;
    logic              oValid;
    logic              iReady;
    logic [ADDR_W:0]   oPending;

    modport master (
        input  iRx_addr, iRx_data, iReady,
        output oRead_addr, oData, oValid, oPending
    );

    modport slave (
        output iRx_addr, iRx_data, iReady,
        input  oRead_addr, oData, oValid, oPending
    );
endinterface

// File: rtl/rs232_rx_drain.sv
// rs232_rx_drain: drains the pointer-polled RS232 receive buffer into a valid/ready byte stream
// Optional handshake counter on oByte_count when RS232_RX_DRAIN_STATS_EN is defined.
module rs232_rx_drain #(
    parameter int ADDR_W       = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic                  iClk,
    input  logic                  iRst,
`ifdef RS232_RX_DRAIN_STATS_EN
    output logic [15:0]           oByte_count,
`endif
    rs232_rx_drain_if.master      bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);

    state_t            state, stateNext;
    logic [ADDR_W-1:0] rdPtr;
    logic [1:0]        waitCnt;
    logic [7:0]        dataReg;
    logic              capture, consume;

    assign bus.oRead_addr = rdPtr;
    assign bus.oData      = dataReg;
    assign bus.oValid     = state == HOLD;
    assign bus.oPending   = {1'b0, ADDR_W'(bus.iRx_addr - rdPtr)};

    // Next state: wait for a pointer mismatch, ride out the read latency, hold until accepted
    always_comb begin
        capture   = state == FETCH && waitCnt == LAST;
        consume   = state == HOLD && bus.iReady;
        stateNext = state;
        if (state == IDLE && bus.iRx_addr != rdPtr)
            stateNext = FETCH;
        else if (capture)
            stateNext = HOLD;
        else if (consume)
            stateNext = IDLE;
    end

    // State, latency counter, captured byte and read pointer; reset drops any held byte
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state   <= IDLE;
            waitCnt <= '0;
            dataReg <= '0;
            rdPtr   <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= state == FETCH ? waitCnt + 2'd1 : 2'd0;
            if (capture)
                dataReg <= bus.iRx_data;
            if (consume)
                rdPtr <= rdPtr + 1'b1;
        end
    end

`ifdef RS232_RX_DRAIN_STATS_EN
    // Count every accepted byte, wrapping at 16 bits
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst)
            oByte_count <= '0;
        else if (consume)
            oByte_count <= oByte_count + 16'd1;
    end
`endif
endmodule
